// File: rtl/apb_pkg.sv
// Shared state encoding, requester count and defaults for the APB request arbiter.
package apb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin picker: a tie goes to the requester not granted last.
module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two simple requesters onto one APB master port, with a wait-state
// watchdog that terminates stalled transfers with an error response.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*AWIDTH-1:0] req_addr,
  input  logic [2*DWIDTH-1:0] req_wdata,
  output logic [1:0]          done,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [AWIDTH-1:0]   PADDR,
  output logic [DWIDTH-1:0]   PWDATA,
  input  logic [DWIDTH-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output logic [1:0]          dbg_state
);

  // Handshake: req[i] acts as valid and stays high until done[i] pulses for one
  // cycle; done[i] is the completion, with rsp_* valid only in that cycle. The
  // APB side is the usual SETUP/ACCESS sequence, ACCESS ending on PREADY=1.

  localparam logic [7:0] WAIT_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  apb_state_e          state, state_next;
  logic [1:0]          eligible, grant;
  logic                last_grant, winner;
  logic [7:0]          wait_cnt;
  logic                start, finish_ok, finish_to;
  logic                sel_write;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;

  // A requester is ignored during its own done cycle so it can drop req.
  assign eligible = req & ~done;

  apb_rr_arbiter u_rr (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_write = grant[1] ? req_write[1] : req_write[0];
  assign sel_addr  = grant[1] ? req_addr[2*AWIDTH-1:AWIDTH]  : req_addr[AWIDTH-1:0];
  assign sel_wdata = grant[1] ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          start      = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          finish_ok  = 1'b1;
          state_next = ST_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          finish_to  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are captured once at grant, so requester activity during
  // SETUP/ACCESS cannot disturb the transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      if (start) begin
        winner     <= grant[1];
        last_grant <= grant[1];
        PWRITE     <= sel_write;
        PADDR      <= sel_addr;
        PWDATA     <= sel_write ? sel_wdata : '0;
        wait_cnt   <= '0;
      end else if ((state == ST_ACCESS) && !PREADY && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (finish_ok) begin
        done      <= idx_to_onehot(winner);
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (finish_to) begin
        done    <= idx_to_onehot(winner);
        rsp_err <= 1'b1;
      end
    end
  end

  assign PSEL      = (state != ST_IDLE);
  assign PENABLE   = (state == ST_ACCESS);
  assign dbg_state = state;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, APB data width.
REQ-002 SHALL have parameter AWIDTH, default 32, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum consecutive wait cycles in ACCESS (0 = watchdog disabled); legal range 0..255.
REQ-004 SHALL have port PCLK  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  2  per-requester transfer request, held until matching done.
REQ-007 SHALL have port req_write  input  2  per-requester direction, 1 = write.
REQ-008 SHALL have port req_addr  input  2*AWIDTH  requester i address in bits [i*AWIDTH +: AWIDTH].
REQ-009 SHALL have port req_wdata  input  2*DWIDTH  requester i write data in bits [i*DWIDTH +: DWIDTH].
REQ-010 SHALL have port done  output  2  one-cycle completion pulse for requester i.
REQ-011 SHALL have port rsp_rdata  output  DWIDTH  read data, valid while done is non-zero.
REQ-012 SHALL have port rsp_err  output  1  error flag, valid while done is non-zero.
REQ-013 SHALL have ports PSEL, PENABLE, PWRITE (output, 1), PADDR (output, AWIDTH), PWDATA (output, DWIDTH): the APB master request signals.
REQ-014 SHALL have ports PRDATA (input, DWIDTH), PREADY (input, 1), PSLVERR (input, 1): the APB slave response signals.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-016 IDLE: PSEL=0, PENABLE=0; on an eligible request, SHALL latch the winner's write, addr and wdata, then move to SETUP.
REQ-017 Eligible means req[i]=1 and done[i]=0 in the same cycle; a requester that has just been served is ignored during its done cycle.
REQ-018 Arbitration SHALL be round-robin: when both requesters are eligible, the winner is the one not granted last; a single eligible requester always wins.
REQ-019 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0 and latched PADDR/PWRITE/PWDATA, then move to ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable until exit.
REQ-021 ACCESS with PREADY=1 SHALL move to IDLE and, in the next cycle, pulse done[winner]=1 with rsp_rdata=PRDATA for reads or 0 for writes, and rsp_err=PSLVERR.
REQ-022 A wait counter SHALL count ACCESS cycles with PREADY=0, clearing on entry to SETUP.
REQ-023 When TIMEOUT is non-zero and the counter reaches TIMEOUT, the block SHALL move to IDLE and pulse done[winner] with rsp_err=1 and rsp_rdata=0.
REQ-024 Latency SHALL be: req seen in IDLE at cycle 0, PSEL at cycle 1, PENABLE at cycle 2, done at cycle 3 with a zero-wait slave.
REQ-025 PWDATA SHALL drive the latched data for writes and 0 for reads.
REQ-026 done SHALL be one-hot or zero; rsp_rdata and rsp_err SHALL be 0 when done=0.
REQ-027 Changes on req_* while a transfer is in SETUP or ACCESS SHALL have no effect on the transfer in progress.

Reset
REQ-028 Asserting PRESETn low SHALL asynchronously force IDLE, all outputs to 0, the wait counter to 0, and the round-robin pointer so that requester 0 wins the first tie.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the transfer is lost.

Structure
REQ-030 State encoding, the requester count (2) and the default TIMEOUT SHALL live in shared package apb_pkg.
REQ-031 The round-robin picker SHALL be a sub-module apb_rr_arbiter (inputs: eligible[1:0], last-grant pointer; output: one-hot grant).

Verification
REQ-032 req=01, write, addr 0x0, wdata 0xDEADBEEF, PREADY=1 -> PSEL at cycle 1, PENABLE at cycle 2, done=01 at cycle 3, rsp_err=0.
REQ-033 req=11 simultaneously after reset, both reads, slave PRDATA 0x11/0x22 -> requester 0 served first (rdata 0x11), requester 1 next (rdata 0x22), PSEL for second transfer at cycle 4.
REQ-034 Read with PREADY low for 3 cycles then high, PRDATA 0xA5A5A5A5 -> address stable over the 3 waits, done after the 4th ACCESS cycle, rsp_rdata=0xA5A5A5A5.
REQ-035 TIMEOUT=4, PREADY held 0 -> exit after 4 wait cycles, done pulse with rsp_err=1, rsp_rdata=0, PSEL=0 the next cycle.
REQ-036 Transfer with PSLVERR=1 on the ready cycle -> rsp_err=1 during done; then PRESETn pulsed low during ACCESS -> PSEL=PENABLE=0 immediately, no done.
